// File: rtl/interrupt_dispatcher.sv
// rtl/interrupt_dispatcher.sv - edge-latching interrupt dispatcher offering the lowest pending line to a round-robin thread
// Optional offer timeout is compiled in when INT_DISPATCH_TIMEOUT_EN is defined.
`ifndef THREADS_PER_CORE
`define THREADS_PER_CORE 4
`endif

module interrupt_dispatcher #(
  parameter int NUM_INTERRUPTS = 16,
  parameter int NUM_THREADS    = `THREADS_PER_CORE,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_INTERRUPTS-1:0]      interrupt_req,
  input  logic [NUM_INTERRUPTS-1:0]      interrupt_mask,
  input  logic [NUM_THREADS-1:0]         thread_eligible,
  input  logic                           ack_valid,
  input  logic [$clog2(NUM_THREADS)-1:0] ack_thread_idx,
  input  logic [4:0]                     ack_vector,
  output logic [NUM_THREADS-1:0]         dsp_pending,
  output logic [4:0]                     dsp_vector,
  output logic [NUM_INTERRUPTS-1:0]      dsp_latched
);

  localparam int TIDX_W = $clog2(NUM_THREADS);

  if (NUM_INTERRUPTS < 1 || NUM_INTERRUPTS > 32) begin : g_bad_num_interrupts
    $error("NUM_INTERRUPTS must be 1..32");
  end
  if (NUM_THREADS < 2 || (NUM_THREADS & (NUM_THREADS - 1)) != 0) begin : g_bad_num_threads
    $error("NUM_THREADS must be a power of 2, at least 2");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic {S_IDLE, S_OFFERED} state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [NUM_INTERRUPTS-1:0] r_req_prev;
  logic [NUM_INTERRUPTS-1:0] r_latched;
  logic [TIDX_W-1:0]         r_rr_ptr;
  logic [TIDX_W-1:0]         r_tgt;
  logic [NUM_THREADS-1:0]    r_pending;
  logic [4:0]                r_vector;

  logic [NUM_INTERRUPTS-1:0] w_edge;
  logic [NUM_INTERRUPTS-1:0] w_cand;
  logic [NUM_INTERRUPTS-1:0] w_clear;
  logic [4:0]                w_low_vec;
  logic [TIDX_W-1:0]         w_tgt;
  logic                      w_dispatch;
  logic                      w_ack_match;
  logic                      w_timeout;
  logic                      w_release;
  logic [NUM_THREADS-1:0]    w_pending_nxt;
  logic [4:0]                w_vector_nxt;

  assign w_edge = interrupt_req & ~r_req_prev;
  assign w_cand = r_latched & interrupt_mask;

  // Descending scan so the lowest set bit is the last one written.
  always_comb begin
    w_low_vec = 5'd0;
    for (int i = NUM_INTERRUPTS - 1; i >= 0; i--) begin
      if (w_cand[i]) begin
        w_low_vec = 5'(i);
      end
    end
  end

  always_comb begin
    logic                found;
    logic [TIDX_W-1:0]   idx;
    w_tgt = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_THREADS; k++) begin
      idx = r_rr_ptr + TIDX_W'(k);
      if (!found && thread_eligible[idx]) begin
        w_tgt = idx;
        found = 1'b1;
      end
    end
  end

  assign w_dispatch  = (r_state == S_IDLE) && (|w_cand) && (|thread_eligible);
  assign w_ack_match = (r_state == S_OFFERED) && ack_valid &&
                       (ack_thread_idx == r_tgt) && (ack_vector == r_vector);

`ifdef INT_DISPATCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_dispatch) begin
      r_cnt <= '0;
    end else if (r_state == S_OFFERED) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // An acknowledge arriving in the timeout cycle takes precedence.
  assign w_timeout = (r_state == S_OFFERED) && !w_ack_match &&
                     (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  assign w_release = w_ack_match || w_timeout;
  assign w_clear   = w_ack_match ? (NUM_INTERRUPTS'(1) << r_vector) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_dispatch) w_state_nxt = S_OFFERED;
      S_OFFERED: if (w_release)  w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Offer outputs are registered; while OFFERED they hold regardless of mask/eligibility.
  always_comb begin
    w_pending_nxt = r_pending;
    w_vector_nxt  = r_vector;
    case (r_state)
      S_IDLE: begin
        if (w_dispatch) begin
          w_pending_nxt = NUM_THREADS'(1) << w_tgt;
          w_vector_nxt  = w_low_vec;
        end else begin
          w_pending_nxt = '0;
        end
      end
      S_OFFERED: begin
        if (w_release) begin
          w_pending_nxt = '0;
        end
      end
      default: w_pending_nxt = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_req_prev <= '0;
      r_latched  <= '0;
      r_rr_ptr   <= '0;
      r_tgt      <= '0;
      r_pending  <= '0;
      r_vector   <= '0;
    end else begin
      r_req_prev <= interrupt_req;
      r_latched  <= (r_latched & ~w_clear) | w_edge;
      r_pending  <= w_pending_nxt;
      r_vector   <= w_vector_nxt;
      if (w_dispatch) begin
        r_tgt <= w_tgt;
      end
      if (w_release) begin
        r_rr_ptr <= r_tgt + TIDX_W'(1);
      end
    end
  end

  assign dsp_pending = r_pending;
  assign dsp_vector  = r_vector;
  assign dsp_latched = r_latched;

endmodule
